// File: rtl/mips_div_pkg.sv
// Shared constants for the multi-cycle DIV/DIVU unit.
// Provides FSM state codes and the ready/start level names.
package mips_div_pkg;

  localparam logic [1:0] DIV_FREE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;

endpackage

// File: rtl/mips_div_step.sv
// One combinational restoring-division step.
// Ports: i_work {rem,quo}, i_divisor -> o_work (next {rem,quo}).
module mips_div_step #(
  parameter int W = 32
) (
  input  logic [2*W:0]  i_work,
  input  logic [W-1:0]  i_divisor,
  output logic [2*W:0]  o_work
);

  logic [2*W:0] w_shift;
  logic [W:0]   w_trial;

  assign w_shift = {i_work[2*W-1:0], 1'b0};
  assign w_trial = w_shift[2*W:W] - {1'b0, i_divisor};

  // Partial remainder stays below 2*divisor, so
  // trial bit W is a reliable borrow flag.
  always_comb begin
    o_work = w_shift;
    if (!w_trial[W])
      o_work = {w_trial, w_shift[W-1:1], 1'b1};
    else
      o_work = {w_shift[2*W:W], w_shift[W-1:1], 1'b0};
  end

endmodule

// File: rtl/mips_div.sv
// Radix-2 restoring divider for DIV/DIVU beside EX.
// Ports: operands/sign/start/annul in; {rem,quo} result_o, ready_o out.
module mips_div
  import mips_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    signed_div_i,
  input  logic [DATA_WIDTH-1:0]   opdata1_i,
  input  logic [DATA_WIDTH-1:0]   opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic                    ready_o
);

  localparam int W = DATA_WIDTH;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*W:0]         r_work;
  logic [W-1:0]         r_divisor;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic [W-1:0] w_op1_abs;
  logic [W-1:0] w_op2_abs;
  logic [2*W:0] w_next;
  logic [W-1:0] w_quo;
  logic [W-1:0] w_rem;
  logic         w_last;
  logic         w_go;
  logic         w_stop;

  assign w_op1_abs = (signed_div_i && opdata1_i[W-1])
                   ? -opdata1_i : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[W-1])
                   ? -opdata2_i : opdata2_i;

  mips_div_step #(.W(W)) u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_next)
  );

  // Remainder sign follows the dividend.
  assign w_quo  = r_neg_q ? -w_next[W-1:0]   : w_next[W-1:0];
  assign w_rem  = r_neg_r ? -w_next[2*W-1:W] : w_next[2*W-1:W];
  assign w_last = (r_cnt == CNT_WIDTH'(W - 1));
  assign w_go   = (start_i == DIV_START) && !annul_i;
  assign w_stop = (start_i == DIV_STOP) || annul_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_NOT_READY;
    end else begin
      unique case (r_state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_NOT_READY;
          if (w_go) begin
            if (opdata2_i == '0) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= '0;
              r_work    <= {{(W+1){1'b0}}, w_op1_abs};
              r_divisor <= w_op2_abs;
              r_neg_q   <= signed_div_i
                         & (opdata1_i[W-1] ^ opdata2_i[W-1]);
              r_neg_r   <= signed_div_i & opdata1_i[W-1];
            end
          end
        end
        DIV_BYZERO: begin
          r_state  <= DIV_END;
          result_o <= '0;
          ready_o  <= DIV_READY;
        end
        DIV_ON: begin
          if (w_stop) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= DIV_NOT_READY;
          end else begin
            r_work <= w_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              result_o <= {w_rem, w_quo};
              ready_o  <= DIV_READY;
              r_state  <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (w_stop) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= DIV_NOT_READY;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div.sv
// Directed bench for mips_div.
// Drives on negedge, samples #1 after posedge.
module tb_mips_div;

  logic        clk;
  logic        rst_n;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk;
  int n_err;

  mips_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full transaction: start, wait for ready, check
  // latency/result/hold, then drop start.
  task automatic do_div(string tag, logic sgn,
                        logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, int lat);
    int n;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        opdata1_i = ~a;
        opdata2_i = 32'h0;
        signed_div_i = ~sgn;
      end
      if (ready_o) break;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, {result_o[62:0], ready_o},
        {exp[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  initial begin
    int seen;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_div("divu_7_2", 1'b0, 32'd7, 32'd2,
           64'h00000001_00000003, 33);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
           64'hFFFFFFFF_FFFFFFFD, 33);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
           64'h00000001_FFFFFFFD, 33);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000, 33);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
           64'h00000000_FFFFFFFF, 33);
    do_div("divu_small", 1'b0, 32'd5, 32'd9,
           64'h00000005_00000000, 33);
    do_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7,
           64'hFFFFFFFE_FFFFFFF2, 33);
    do_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'h80000000,
           64'h7FFFFFFF_00000001, 33);
    do_div("div0_s", 1'b1, 32'h12345678, 32'd0,
           64'd0, 2);
    do_div("div0_u", 1'b0, 32'hFFFFFFFF, 32'd0,
           64'd0, 2);

    // Annul mid-divide: ready must never rise.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o || result_o != 64'd0) seen = 1;
    end
    chk("annul_quiet", 64'(seen), 64'd0);
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7,
           64'h00000002_0000000E, 33);

    // Async reset mid-divide.
    @(negedge clk);
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while a result is held.
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd4;
    start_i = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    chk("pre_rst_end", {result_o[62:0], ready_o},
        {63'h00000001_00000002, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_end", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_div("post_rst", 1'b0, 32'd50, 32'd5,
           64'h00000000_0000000A, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
